fpu_iter: RTL and testbench

Iterative single-precision floating-point execution unit: add, subtract and multiply over a start/busy/done handshake. It is the multi-cycle replacement for the combinational FPU in the core's datapath. It consumes the two FP register-file read ports and feeds the FP write-back path. While `busy` is high, the core holds its PC and register files via the same clock gate used for `halt`.

---
 rtl/fpu_iter_if.sv | 14 +
 rtl/fpu_iter.sv | 183 ++++++++++++++++++
 tb/tb_fpu_iter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fpu_iter_if.sv
// Operand/result handshake between the core's FP datapath and the iterative FPU.
// The core is the master; the FPU is the slave.
interface fpu_iter_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/fpu_iter.sv
// Iterative single-precision add/sub/mul with truncating rounding.
// One bit of alignment, multiplication or normalisation is done per clock.
module fpu_iter #(
    parameter int MUL_STEPS = 24,
    parameter int ALIGN_CAP = 26
) (
    input  logic      clk,
    input  logic      rst,
    fpu_iter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_MUL, S_ADD, S_NORM, S_PACK, S_DONE
    } state_t;

    localparam logic [1:0]        OP_SUB = 2'b01;
    localparam logic [1:0]        OP_RSV = 2'b11;
    localparam logic [31:0]       QNAN   = 32'h7FC0_0000;
    localparam logic signed [9:0] CAP_E  = ALIGN_CAP[9:0];

    // Saturate to Inf / flush to zero; the mantissa is already truncated.
    function automatic logic [31:0] pack_fp(input logic s, input logic signed [9:0] e,
                                            input logic [22:0] f, input logic z);
        if (z)                   return 32'h0000_0000;
        else if (e >= 10'sd255)  return {s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)    return {s, 31'd0};
        else                     return {s, e[7:0], f};
    endfunction

    state_t             r_state;
    logic               r_phase;
    logic [5:0]         r_cnt;
    logic               r_busy, r_done;
    logic [31:0]        r_result;

    logic [31:0]        r_a, r_b;
    logic [1:0]         r_op;
    logic               r_sa, r_sb, r_special;
    logic signed [9:0]  r_ea, r_eb;
    logic [23:0]        r_ma, r_mb;
    logic               r_sx, r_sy, r_zero;
    logic signed [9:0]  r_ex;
    logic [24:0]        r_mx;
    logic [23:0]        r_my;
    logic [47:0]        r_acc, r_mcand;
    logic [23:0]        r_mplier;

    logic               w_a_ge_b, w_cap, w_norm_done;
    logic signed [9:0]  w_d;
    logic [24:0]        w_sum;

    assign w_a_ge_b    = {r_ea[7:0], r_ma} >= {r_eb[7:0], r_mb};
    assign w_d         = w_a_ge_b ? (r_ea - r_eb) : (r_eb - r_ea);
    assign w_cap       = w_d >= CAP_E;
    assign w_sum       = (r_sx == r_sy) ? (r_mx + {1'b0, r_my}) : (r_mx - {1'b0, r_my});
    // Look one bit ahead so a single left shift that lands on bit 23 finishes NORM.
    assign w_norm_done = r_op[1] || (r_mx == 25'd0) || r_mx[24] || r_mx[23] || r_mx[22];

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_phase  <= 1'b0;
            r_cnt    <= 6'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'h0000_0000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_state <= S_UNPACK;
                    r_phase <= 1'b0;
                    r_busy  <= 1'b1;
                end
                // UNPACK spends one cycle splitting fields, a second comparing and dispatching.
                S_UNPACK: if (!r_phase) begin
                    r_phase <= 1'b1;
                end else if (r_op == OP_RSV) begin
                    r_result <= 32'h0000_0000;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end else if (r_special) begin
                    r_result <= QNAN;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end else if (r_op[1]) begin
                    r_cnt   <= MUL_STEPS[5:0];
                    r_state <= S_MUL;
                end else if (w_cap || (w_d == 10'sd0)) begin
                    r_state <= S_ADD;
                end else begin
                    r_cnt   <= w_d[5:0];
                    r_state <= S_ALIGN;
                end
                S_ALIGN: begin
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) r_state <= S_ADD;
                end
                S_MUL: begin
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) r_state <= S_NORM;
                end
                S_ADD:  r_state <= S_NORM;
                S_NORM: if (w_norm_done) r_state <= S_PACK;
                S_PACK: begin
                    r_result <= pack_fp(r_sx, r_ex, r_mx[22:0], r_zero);
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: if (bus.start) begin
                r_a  <= bus.a;
                r_b  <= bus.b;
                r_op <= bus.op;
            end
            S_UNPACK: if (!r_phase) begin
                r_sa      <= r_a[31];
                r_sb      <= r_b[31] ^ (r_op == OP_SUB);
                r_ea      <= {2'b00, r_a[30:23]};
                r_eb      <= {2'b00, r_b[30:23]};
                r_ma      <= (r_a[30:23] == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
                r_mb      <= (r_b[30:23] == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};
                r_special <= (r_a[30:23] == 8'hFF) || (r_b[30:23] == 8'hFF);
            end else begin
                r_zero <= 1'b0;
                if (r_op[1]) begin
                    r_sx     <= r_sa ^ r_sb;
                    r_ex     <= r_ea + r_eb - 10'sd127;
                    r_acc    <= 48'd0;
                    r_mcand  <= {24'd0, r_ma};
                    r_mplier <= r_mb;
                end else begin
                    r_sx <= w_a_ge_b ? r_sa : r_sb;
                    r_sy <= w_a_ge_b ? r_sb : r_sa;
                    r_ex <= w_a_ge_b ? r_ea : r_eb;
                    r_mx <= {1'b0, (w_a_ge_b ? r_ma : r_mb)};
                    r_my <= w_cap ? 24'd0 : (w_a_ge_b ? r_mb : r_ma);
                end
            end
            S_ALIGN: r_my <= r_my >> 1;
            S_MUL: begin
                r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 48'd0);
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
            S_ADD: r_mx <= w_sum;
            S_NORM: if (r_op[1]) begin
                if (r_acc == 48'd0) begin
                    r_zero <= 1'b1;
                end else if (r_acc[47]) begin
                    r_mx <= {1'b0, r_acc[47:24]};
                    r_ex <= r_ex + 10'sd1;
                end else begin
                    r_mx <= {1'b0, r_acc[46:23]};
                end
            end else begin
                if (r_mx == 25'd0) begin
                    r_zero <= 1'b1;
                end else if (r_mx[24]) begin
                    r_mx <= r_mx >> 1;
                    r_ex <= r_ex + 10'sd1;
                end else if (!r_mx[23]) begin
                    r_mx <= r_mx << 1;
                    r_ex <= r_ex - 10'sd1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fpu_iter.sv
// Directed-vector bench for fpu_iter: results, completion edge, handshake and reset.
module tb_fpu_iter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fpu_iter_if bus ();

    fpu_iter #(.MUL_STEPS(24), .ALIGN_CAP(26)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one operation from an IDLE cycle; check busy, completion edge, result, return to idle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_edge);
        int done_at;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0BAD_F00D;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        done_at = -1;
        for (int n = 1; n <= 80 && done_at < 0; n++) begin
            @(posedge clk); #1;
            if (bus.done) done_at = n;
        end
        chk({tag, "_edge"}, 32'(done_at), 32'(exp_edge));
        chk({tag, "_res"}, bus.result, exp_res);
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        int done_at;
        int ndone;
        int first_done;
        n_checks  = 0;
        n_errors  = 0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        chk("rst_state", {bus.done, bus.busy, 30'd0}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        #13 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_1p1",     2'b00, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 5);
        run_op("mul_1p5x2",   2'b10, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 28);
        run_op("mul_ovf",     2'b10, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 28);
        run_op("sub_cancel",  2'b01, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 5);
        run_op("sub_half",    2'b01, 32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000, 5);
        run_op("sub_norm2",   2'b01, 32'h3FA0_0000, 32'h3F80_0000, 32'h3E80_0000, 6);
        run_op("sub_neg",     2'b01, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 6);
        run_op("add_d24",     2'b00, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 29);
        run_op("add_2p24_d24",2'b00, 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 29);
        run_op("add_d26_cap", 2'b00, 32'h3F80_0000, 32'h3280_0000, 32'h3F80_0000, 5);
        run_op("add_d32_cap", 2'b00, 32'h4F80_0000, 32'h3F80_0000, 32'h4F80_0000, 5);
        run_op("inf_add",     2'b00, 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 2);
        run_op("denorm_mul",  2'b10, 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 28);
        run_op("reserved_op", 2'b11, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 2);

        // Start pulses while a multiply is in flight must be ignored.
        bus.op = 2'b10; bus.a = 32'h3FC0_0000; bus.b = 32'h4000_0000; bus.start = 1'b1;
        @(posedge clk); #1;
        ndone = 0; done_at = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 3 || n == 10) begin
                bus.start = 1'b1; bus.op = 2'b00;
                bus.a = 32'h4040_0000; bus.b = 32'h4040_0000;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.done) begin ndone++; done_at = n; end
        end
        chk("busy_start_ndone", 32'(ndone), 32'd1);
        chk("busy_start_edge", 32'(done_at), 32'd28);
        chk("busy_start_res", bus.result, 32'h4040_0000);
        chk("busy_start_idle", 32'(bus.busy), 32'd0);

        // start held high: second op accepted at the first IDLE edge after done.
        bus.op = 2'b00; bus.a = 32'h3F80_0000; bus.b = 32'h3F80_0000; bus.start = 1'b1;
        @(posedge clk); #1;
        ndone = 0; first_done = -1; done_at = -1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (n == 6) chk("b2b_gap_busy", 32'(bus.busy), 32'd0);
            if (n == 7) chk("b2b_reaccept_busy", 32'(bus.busy), 32'd1);
            if (bus.done) begin
                ndone++;
                if (first_done < 0) first_done = n; else done_at = n;
            end
        end
        bus.start = 1'b0;
        chk("b2b_ndone", 32'(ndone), 32'd2);
        chk("b2b_first", 32'(first_done), 32'd5);
        chk("b2b_second", 32'(done_at), 32'd12);
        chk("b2b_res", bus.result, 32'h4000_0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a multiply.
        bus.op = 2'b10; bus.a = 32'h3FC0_0000; bus.b = 32'h4000_0000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_result", bus.result, 32'd0);
        chk("async_rst_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ndone = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) ndone++;
        end
        chk("post_rst_quiet", 32'(ndone), 32'd0);
        run_op("post_rst_add", 2'b00, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
